spi_initiator: RTL and testbench

SPI_INITIATOR -- requirements
Module: spi_initiator

---
 rtl/spi_initiator_pkg.sv | 27 ++
 rtl/spi_initiator_clk_div.sv | 32 +++
 rtl/spi_initiator.sv | 149 ++++++++++++++
 tb/tb_spi_initiator.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_initiator_pkg.sv
// Shared SPI initiator constants: FSM state encoding, default parameters,
// and a small helper that sizes the phase counter.
package spi_initiator_pkg;

    localparam int unsigned DEF_WORD_BITS = 64;
    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_CS_SETUP  = 2;
    localparam int unsigned DEF_CS_HOLD   = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCK_LO = 3'd2,
        ST_SCK_HI = 3'd3,
        ST_HOLD   = 3'd4
    } spi_state_e;

    // Longest of the three phase lengths, used to size the phase counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_initiator_clk_div.sv
// Phase counter for the SPI initiator.
// Ports: CLK/resetn clock and async active-low reset; load reloads the
// counter with load_val (phase length minus one); tick_c is high in the
// last cycle of the current phase.
module spi_clk_div
    import spi_initiator_pkg::*;
#(
    parameter int unsigned CNT_W = $clog2(DEF_CLK_DIV + 1)
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick_c
);

    logic [CNT_W-1:0] cnt_q;

    // Down-counter: reloaded on every phase change, parks at zero.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign tick_c = (cnt_q == '0);

endmodule

// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: one WORD_BITS word per transfer, MSB first,
// full duplex.
// Ports: CLK/resetn clock and async active-low reset; tx_data/tx_valid/
// tx_ready accept a word in IDLE; rx_data/rx_valid return the received
// word; busy is high outside IDLE; SCK/CS/COPI/CIPO are the SPI pins.
module spi_initiator
    import spi_initiator_pkg::*;
#(
    parameter int unsigned WORD_BITS = DEF_WORD_BITS,
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned CS_SETUP  = DEF_CS_SETUP,
    parameter int unsigned CS_HOLD   = DEF_CS_HOLD
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 SCK,
    output logic                 CS,
    output logic                 COPI,
    input  logic                 CIPO
);

    localparam int unsigned BCNT_W = $clog2(WORD_BITS + 1);
    localparam int unsigned DIV_W  = $clog2(max3(CLK_DIV, CS_SETUP, CS_HOLD) + 1);

    spi_state_e           state_q, state_d;
    logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] tx_sh_q, tx_sh_d;
    logic [WORD_BITS-1:0] rx_sh_q, rx_sh_d;
    logic [WORD_BITS-1:0] rx_data_d;
    logic                 rx_valid_d, copi_d;
    logic                 accept_c, words_done_c, tick_c, div_load_c;
    logic [DIV_W-1:0]     div_val_c;

    assign accept_c     = tx_valid && tx_ready;
    assign words_done_c = (bit_cnt_q == BCNT_W'(WORD_BITS));

    spi_clk_div #(
        .CNT_W (DIV_W)
    ) u_clk_div (
        .CLK      (CLK),
        .resetn   (resetn),
        .load     (div_load_c),
        .load_val (div_val_c),
        .tick_c   (tick_c)
    );

    // State register.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. After the last sample a final SCK_LO completes the last
    // SCK period before HOLD, so every bit gets a full high/low cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept_c) state_d = ST_SETUP;
            ST_SETUP:  if (tick_c)   state_d = ST_SCK_HI;
            ST_SCK_HI: if (tick_c)   state_d = ST_SCK_LO;
            ST_SCK_LO: if (tick_c)   state_d = words_done_c ? ST_HOLD : ST_SCK_HI;
            ST_HOLD:   if (tick_c)   state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; divider reloads on every state change.
    always_comb begin
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        bit_cnt_d  = bit_cnt_q;
        copi_d     = COPI;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        div_load_c = (state_d != state_q);
        div_val_c  = '0;

        case (state_d)
            ST_SETUP:             div_val_c = DIV_W'(CS_SETUP - 1);
            ST_SCK_HI, ST_SCK_LO: div_val_c = DIV_W'(CLK_DIV - 1);
            ST_HOLD:              div_val_c = DIV_W'(CS_HOLD - 1);
            default:              div_val_c = '0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    tx_sh_d   = tx_data;
                    copi_d    = tx_data[WORD_BITS-1];
                    bit_cnt_d = '0;
                end
            end
            ST_SCK_HI: begin
                if (tick_c) begin
                    rx_sh_d   = {rx_sh_q[WORD_BITS-2:0], CIPO};
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    if (bit_cnt_q != BCNT_W'(WORD_BITS - 1)) begin
                        tx_sh_d = tx_sh_q << 1;
                        copi_d  = tx_sh_q[WORD_BITS-2];
                    end
                end
            end
            ST_HOLD: begin
                if (tick_c) begin
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; pin levels follow the next state.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            bit_cnt_q <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_ready  <= 1'b0;
            busy      <= 1'b0;
            SCK       <= 1'b0;
            CS        <= 1'b1;
            COPI      <= 1'b0;
        end else begin
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            bit_cnt_q <= bit_cnt_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            tx_ready  <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            SCK       <= (state_d == ST_SCK_HI);
            CS        <= (state_d == ST_IDLE);
            COPI      <= copi_d;
        end
    end

endmodule

// File: tb/tb_spi_initiator.sv
// Self-checking bench for spi_initiator: a default 64-bit instance with a
// loopback/responder mux on CIPO, and an 8-bit CLK_DIV=1 loopback instance.
module tb_spi_initiator;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Instance A: defaults
    logic [63:0] tx_data_a = '0;
    logic [63:0] rx_data_a;
    logic tx_valid_a = 1'b0;
    logic tx_ready_a, rx_valid_a, busy_a, sck_a, cs_a, copi_a, cipo_a;
    logic loop_a = 1'b1;

    // Instance B: 8 bits, CLK_DIV=1, loopback
    logic [7:0] tx_data_b = '0;
    logic [7:0] rx_data_b;
    logic tx_valid_b = 1'b0;
    logic tx_ready_b, rx_valid_b, busy_b, sck_b, cs_b, copi_b;

    // Mode-0 responder model (reacts one CLK after each SCK/CS edge)
    logic [63:0] resp_word = '0;
    logic [63:0] resp_sh   = '0;
    logic [63:0] resp_cap  = '0;
    logic cs_prev = 1'b1, sck_prev = 1'b0;

    assign cipo_a = loop_a ? copi_a : resp_sh[63];

    logic [63:0] exp_q_a[$];
    logic [7:0]  exp_q_b[$];

    spi_initiator u_dut_a (
        .CLK(clk), .resetn(rst_n),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a),
        .SCK(sck_a), .CS(cs_a), .COPI(copi_a), .CIPO(cipo_a)
    );

    spi_initiator #(.WORD_BITS(8), .CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2)) u_dut_b (
        .CLK(clk), .resetn(rst_n),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b),
        .SCK(sck_b), .CS(cs_b), .COPI(copi_b), .CIPO(copi_b)
    );

    always @(posedge clk) begin
        if (cs_prev && !cs_a) begin
            resp_sh  <= resp_word;
            resp_cap <= '0;
        end else if (!cs_a) begin
            if (!sck_prev && sck_a) resp_cap <= {resp_cap[62:0], copi_a};
            if (sck_prev && !sck_a) resp_sh  <= resp_sh << 1;
        end
        cs_prev  <= cs_a;
        sck_prev <= sck_a;
    end

    // Pin monitors: CS low/high run lengths, SCK period, rx_valid pulses
    int cyc = 0;
    int low_run_a = 0, last_low_a = 0, high_run_a = 0, last_high_a = 0;
    int rxv_a = 0, rise_a = 0, per_a = 0;
    int low_run_b = 0, last_low_b = 0, rxv_b = 0, rise_b = 0, per_b = 0;
    logic sckp_a = 1'b0, sckp_b = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!cs_a) low_run_a <= low_run_a + 1;
        else if (low_run_a != 0) begin last_low_a <= low_run_a; low_run_a <= 0; end
        if (cs_a) high_run_a <= high_run_a + 1;
        else if (high_run_a != 0) begin last_high_a <= high_run_a; high_run_a <= 0; end
        if (rx_valid_a) rxv_a <= rxv_a + 1;
        sckp_a <= sck_a;
        if (sck_a && !sckp_a) begin per_a <= cyc - rise_a; rise_a <= cyc; end
        if (!cs_b) low_run_b <= low_run_b + 1;
        else if (low_run_b != 0) begin last_low_b <= low_run_b; low_run_b <= 0; end
        if (rx_valid_b) rxv_b <= rxv_b + 1;
        sckp_b <= sck_b;
        if (sck_b && !sckp_b) begin per_b <= cyc - rise_b; rise_b <= cyc; end
    end

    task automatic send_a(input logic [63:0] d);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_ready_a) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got) begin
            n_fails++;
            $display("FAIL send_a_ready: tx_ready=%0b required 1", tx_ready_a);
        end else begin
            tx_data_a = d; tx_valid_a = 1'b1;
            @(negedge clk);
            tx_valid_a = 1'b0;
        end
    endtask

    task automatic send_b(input logic [7:0] d);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_ready_b) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got) begin
            n_fails++;
            $display("FAIL send_b_ready: tx_ready=%0b required 1", tx_ready_b);
        end else begin
            tx_data_b = d; tx_valid_b = 1'b1;
            @(negedge clk);
            tx_valid_b = 1'b0;
        end
    endtask

    task automatic wait_rx_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_valid_a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_rx_b(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_valid_b) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_checks++;
        if ({cs_a, sck_a, copi_a, rx_valid_a, busy_a, tx_ready_a} !== 6'b100000) begin
            n_fails++;
            $display("FAIL reset_ctrl_a: {cs,sck,copi,rxv,busy,rdy}=%b required 100000",
                     {cs_a, sck_a, copi_a, rx_valid_a, busy_a, tx_ready_a});
        end
        n_checks++;
        if (rx_data_a !== 64'h0) begin
            n_fails++;
            $display("FAIL reset_rx_data_a: got %h required 0", rx_data_a);
        end
        n_checks++;
        if ({cs_b, sck_b, copi_b, rx_valid_b, busy_b, tx_ready_b, rx_data_b} !== {6'b100000, 8'h00}) begin
            n_fails++;
            $display("FAIL reset_b: got %b required 10000000000000",
                     {cs_b, sck_b, copi_b, rx_valid_b, busy_b, tx_ready_b, rx_data_b});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (tx_ready_a !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_ready_before_edge: got %b required 0", tx_ready_a);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({tx_ready_a, busy_a, tx_ready_b} !== 3'b101) begin
            n_fails++;
            $display("FAIL reset_ready_after_edge: {rdy_a,busy_a,rdy_b}=%b required 101",
                     {tx_ready_a, busy_a, tx_ready_b});
        end
    endtask

    task automatic test_loopback();
        bit ok; logic [63:0] exp; int base;
        loop_a = 1'b1;
        base = rxv_a;
        exp_q_a.push_back(64'h0123456789ABCDEF);
        send_a(64'h0123456789ABCDEF);
        wait_rx_a(2000, ok);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL loopback_rxv: rx_valid=%b required 1 within budget", rx_valid_a);
        end else begin
            exp = exp_q_a.pop_front();
            n_checks++;
            if (rx_data_a !== exp) begin
                n_fails++;
                $display("FAIL loopback_data: got %h required %h", rx_data_a, exp);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (last_low_a != 516) begin
            n_fails++;
            $display("FAIL loopback_cs_low: got %0d required 516", last_low_a);
        end
        n_checks++;
        if (rxv_a - base != 1) begin
            n_fails++;
            $display("FAIL loopback_pulses: got %0d required 1", rxv_a - base);
        end
        n_checks++;
        if (per_a != 8) begin
            n_fails++;
            $display("FAIL loopback_sck_period: got %0d required 8", per_a);
        end
    endtask

    task automatic test_responder();
        bit ok; logic [63:0] exp;
        loop_a = 1'b0;
        resp_word = 64'hA5A5_0000_FFFF_5A5A;
        exp_q_a.push_back(64'hA5A5_0000_FFFF_5A5A);
        send_a(64'h0100000000000000);
        wait_rx_a(2000, ok);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL responder_rxv: rx_valid=%b required 1 within budget", rx_valid_a);
        end else begin
            exp = exp_q_a.pop_front();
            n_checks++;
            if (rx_data_a !== exp) begin
                n_fails++;
                $display("FAIL responder_data: got %h required %h", rx_data_a, exp);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (resp_cap !== 64'h0100000000000000) begin
            n_fails++;
            $display("FAIL responder_capture: got %h required 0100000000000000", resp_cap);
        end
        loop_a = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit ok, got; logic [63:0] exp; int base;
        loop_a = 1'b1;
        base = rxv_a;
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_ready_a) begin got = 1'b1; break; end
        end
        tx_data_a = 64'h1; tx_valid_a = 1'b1;
        exp_q_a.push_back(64'h1);
        @(negedge clk);
        tx_data_a = 64'h2;
        exp_q_a.push_back(64'h2);
        // The first IDLE cycle coincides with the first word's rx_valid.
        got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx_ready_a) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got || rx_valid_a !== 1'b1) begin
            n_fails++;
            $display("FAIL b2b_first_rxv: ready=%b rx_valid=%b required 1 1", got, rx_valid_a);
        end else begin
            exp = exp_q_a.pop_front();
            n_checks++;
            if (rx_data_a !== exp) begin
                n_fails++;
                $display("FAIL b2b_first_data: got %h required %h", rx_data_a, exp);
            end
        end
        @(negedge clk);
        tx_valid_a = 1'b0;
        wait_rx_a(2000, ok);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL b2b_second_rxv: rx_valid=%b required 1 within budget", rx_valid_a);
        end else begin
            exp = exp_q_a.pop_front();
            n_checks++;
            if (rx_data_a !== exp) begin
                n_fails++;
                $display("FAIL b2b_second_data: got %h required %h", rx_data_a, exp);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (last_high_a != 1) begin
            n_fails++;
            $display("FAIL b2b_cs_gap: got %0d required 1", last_high_a);
        end
        n_checks++;
        if (rxv_a - base != 2) begin
            n_fails++;
            $display("FAIL b2b_pulses: got %0d required 2", rxv_a - base);
        end
    endtask

    task automatic test_reset_abort();
        bit ok, got; logic [63:0] exp; int base, rises; logic prev;
        loop_a = 1'b1;
        base = rxv_a;
        send_a(64'hFFFF_0000_1234_5678);
        rises = 0; prev = sck_a; got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (sck_a && !prev) rises++;
            prev = sck_a;
            if (rises == 30) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got) begin
            n_fails++;
            $display("FAIL abort_sck_edges: got %0d rising edges required 30", rises);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cs_a, sck_a, busy_a} !== 3'b100) begin
            n_fails++;
            $display("FAIL abort_async: {cs,sck,busy}=%b required 100", {cs_a, sck_a, busy_a});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (rxv_a != base) begin
            n_fails++;
            $display("FAIL abort_no_rxv: got %0d pulses required 0", rxv_a - base);
        end
        exp_q_a.push_back(64'hDEADBEEF);
        send_a(64'hDEADBEEF);
        wait_rx_a(2000, ok);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL abort_next_rxv: rx_valid=%b required 1 within budget", rx_valid_a);
        end else begin
            exp = exp_q_a.pop_front();
            n_checks++;
            if (rx_data_a !== exp) begin
                n_fails++;
                $display("FAIL abort_next_data: got %h required %h", rx_data_a, exp);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (last_low_a != 516) begin
            n_fails++;
            $display("FAIL abort_next_cs_low: got %0d required 516", last_low_a);
        end
    endtask

    task automatic test_mid_pulse();
        bit ok; logic [63:0] exp; int base, idle_cycles;
        loop_a = 1'b1;
        base = rxv_a;
        exp_q_a.push_back(64'h1234_5678_9ABC_DEF0);
        send_a(64'h1234_5678_9ABC_DEF0);
        repeat (100) @(negedge clk);
        n_checks++;
        if ({busy_a, tx_ready_a} !== 2'b10) begin
            n_fails++;
            $display("FAIL mid_busy: {busy,ready}=%b required 10", {busy_a, tx_ready_a});
        end
        tx_data_a = 64'hFFFF; tx_valid_a = 1'b1;
        @(negedge clk);
        tx_valid_a = 1'b0;
        idle_cycles = 0; ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rx_valid_a) begin ok = 1'b1; break; end
            if (!busy_a) idle_cycles++;
        end
        n_checks++;
        if (!ok || idle_cycles != 0) begin
            n_fails++;
            $display("FAIL mid_busy_hold: done=%b non-busy cycles=%0d required 1 0", ok, idle_cycles);
        end
        if (ok) begin
            exp = exp_q_a.pop_front();
            n_checks++;
            if (rx_data_a !== exp) begin
                n_fails++;
                $display("FAIL mid_data: got %h required %h", rx_data_a, exp);
            end
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (rxv_a - base != 1 || busy_a !== 1'b0) begin
            n_fails++;
            $display("FAIL mid_ignored: pulses=%0d busy=%b required 1 0", rxv_a - base, busy_a);
        end
    endtask

    task automatic test_div1();
        bit ok; logic [7:0] exp; int base;
        logic [7:0] words [3];
        words[0] = 8'h81; words[1] = 8'h5C; words[2] = 8'h00;
        foreach (words[k]) begin
            base = rxv_b;
            exp_q_b.push_back(words[k]);
            send_b(words[k]);
            wait_rx_b(200, ok);
            n_checks++;
            if (!ok) begin
                n_fails++;
                $display("FAIL div1_rxv[%0d]: rx_valid=%b required 1 within budget", k, rx_valid_b);
            end else begin
                exp = exp_q_b.pop_front();
                n_checks++;
                if (rx_data_b !== exp) begin
                    n_fails++;
                    $display("FAIL div1_data[%0d]: got %h required %h", k, rx_data_b, exp);
                end
            end
            repeat (3) @(negedge clk);
            n_checks++;
            if (last_low_b != 20 || per_b != 2 || rxv_b - base != 1) begin
                n_fails++;
                $display("FAIL div1_timing[%0d]: cs_low=%0d period=%0d pulses=%0d required 20 2 1",
                         k, last_low_b, per_b, rxv_b - base);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loopback();
        test_responder();
        test_back_to_back();
        test_reset_abort();
        test_mid_pulse();
        test_div1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
